// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes common to the ALU decoder
// and the execute stage.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_XNOR = 4'b0011,
        ALU_ADD  = 4'b0100,
        ALU_SUB  = 4'b1100,
        ALU_SLT  = 4'b1101
    } alu_op_e;

    localparam int ALU_OP_W = 4;
    localparam int RD_W     = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, signed overflow and illegal-op
// detection for one operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [WIDTH-1:0]    a_i,
    input  logic [WIDTH-1:0]    b_i,
    output logic [WIDTH-1:0]    result_o,
    output logic                ovf_o,
    output logic                illegal_o
);

    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra sign bit: overflow is a mismatch of the top two bits,
    // and the top bit of the difference is the exact signed compare.
    assign a_x  = {a_i[WIDTH-1], a_i};
    assign b_x  = {b_i[WIDTH-1], b_i};
    assign sum  = a_x + b_x;
    assign diff = a_x - b_x;

    always_comb begin
        result_o  = '0;
        ovf_o     = 1'b0;
        illegal_o = 1'b0;
        unique case (op_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_XNOR: result_o = ~(a_i ^ b_i);
            ALU_ADD: begin
                result_o = sum[WIDTH-1:0];
                ovf_o    = sum[WIDTH] ^ sum[WIDTH-1];
            end
            ALU_SUB: begin
                result_o = diff[WIDTH-1:0];
                ovf_o    = diff[WIDTH] ^ diff[WIDTH-1];
            end
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: valid/ready handshake around alu_core with a
// single output register toward MEM.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [ALU_OP_W-1:0] ALU_Op,
    input  logic [WIDTH-1:0]    Src_A,
    input  logic [WIDTH-1:0]    Src_B,
    input  logic [RD_W-1:0]     Rd_In,
    input  logic                Flush,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic [WIDTH-1:0]    Result,
    output logic                Zero,
    output logic                Ovf,
    output logic                Illegal,
    output logic [RD_W-1:0]     Rd_Out
);

    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic             core_ill;
    logic             take;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, ovf_q, ill_q;
    logic [RD_W-1:0]  rd_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i      (ALU_Op),
        .a_i       (Src_A),
        .b_i       (Src_B),
        .result_o  (core_res),
        .ovf_o     (core_ovf),
        .illegal_o (core_ill)
    );

    assign In_Ready = !valid_q || Out_Ready;
    assign take     = In_Valid && In_Ready && !Flush;

    // Flush wins over capture and over a stalled result.
    always_comb begin
        valid_d = valid_q;
        if (Flush)
            valid_d = 1'b0;
        else if (take)
            valid_d = 1'b1;
        else if (Out_Ready)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (take) begin
                res_q  <= core_res;
                zero_q <= (core_res == '0);
                ovf_q  <= core_ovf;
                ill_q  <= core_ill;
                rd_q   <= Rd_In;
            end
        end
    end

    assign Out_Valid = valid_q;
    assign Result    = res_q;
    assign Zero      = zero_q;
    assign Ovf       = ovf_q;
    assign Illegal   = ill_q;
    assign Rd_Out    = rd_q;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have In_Valid  input  1  upstream (decode) holds a valid operation.
REQ-005 SHALL have In_Ready  output  1  stage can accept an operation this cycle.
REQ-006 SHALL have ALU_Op  input  4  operation code from the ALU decoder.
REQ-007 SHALL have Src_A, Src_B  input  WIDTH  operands.
REQ-008 SHALL have Rd_In  input  5  destination register tag.
REQ-009 SHALL have Flush  input  1  kill registered and incoming operation.
REQ-010 SHALL have Out_Valid  output  1  Result/flags/Rd_Out valid.
REQ-011 SHALL have Out_Ready  input  1  downstream (MEM) accepts this cycle.
REQ-012 SHALL have Result  output  WIDTH  registered ALU result.
REQ-013 SHALL have Zero, Ovf, Illegal  output  1 each  result==0, signed overflow, unknown ALU_Op.
REQ-014 SHALL have Rd_Out  output  5  registered destination tag.

Function
REQ-015 SHALL decode ALU_Op: 0000 AND, 0001 OR, 0010 XOR, 0011 XNOR, 0100 ADD, 1100 SUB (A-B), 1101 SLT (signed A<B -> 1 else 0, zero-extended).
REQ-016 SHALL treat every other ALU_Op value as illegal: Result 0, Zero 1, Ovf 0, Illegal 1.
REQ-017 SHALL compute ADD/SUB modulo 2^WIDTH; Ovf set only for ADD/SUB on two's-complement overflow, 0 for all other ops.
REQ-018 SHALL compute SLT from the sign of the WIDTH+1-bit difference, correct across the full signed range.
REQ-019 SHALL set Zero when the registered Result equals 0, for every op.
REQ-020 SHALL drive In_Ready = !Out_Valid || Out_Ready (combinational, no dependence on In_Valid).
REQ-021 SHALL capture ALU_Op/operand result, flags, and Rd_In into the output register on a cycle where In_Valid && In_Ready && !Flush; latency exactly 1 cycle.
REQ-022 SHALL hold Result, flags, Rd_Out, Out_Valid unchanged while Out_Valid && !Out_Ready (stall).
REQ-023 SHALL clear Out_Valid when Out_Ready is high and no new capture occurs; output data may stay stale when Out_Valid is 0.
REQ-024 SHALL give Flush priority: next cycle Out_Valid 0 regardless of In_Valid, Out_Ready, or a pending stalled result.
REQ-025 SHALL sustain one operation per cycle when In_Valid and Out_Ready are continuously high.
REQ-026 SHALL count accepted-but-illegal ops in no other way than the Illegal flag; no trap, no stall.

Reset
REQ-027 SHALL, on rst_n low, immediately clear Out_Valid, Result, Zero, Ovf, Illegal, Rd_Out to 0, independent of clk.
REQ-028 SHALL discard any in-flight operation on reset mid-operation; first capture possible on the first rising edge after rst_n deasserts.
REQ-029 SHALL drive In_Ready 1 throughout and after reset (Out_Valid 0).

Structure
REQ-030 SHALL take ALU_Op code constants (AND, OR, XOR, XNOR, ADD, SUB, SLT) from the shared ALU package also used by the ALU decoder.
REQ-031 SHALL place the combinational datapath in one sub-module, alu_core (ALU_Op, A, B -> result, ovf, illegal); alu_exec owns only handshake and output register.

Verification
REQ-032 SHALL check ADD 0x7FFFFFFF + 0x00000001 -> next cycle Out_Valid 1, Result 0x80000000, Ovf 1, Zero 0.
REQ-033 SHALL check SUB 0x00000005 - 0x00000005 -> Result 0, Zero 1, Ovf 0; SLT 0xFFFFFFFF vs 0x00000001 -> Result 1.
REQ-034 SHALL check ALU_Op 0101 with A=0x12345678 -> Result 0, Illegal 1, Zero 1, Out_Valid 1.
REQ-035 SHALL check stall: Out_Ready 0 for 3 cycles after a capture -> In_Ready 0, outputs frozen; Out_Ready 1 -> next op captured same cycle.
REQ-036 SHALL check Flush with In_Valid 1 and a stalled result -> next cycle Out_Valid 0, neither op delivered.
REQ-037 SHALL check rst_n asserted mid-stream between clock edges -> all outputs 0 immediately, In_Ready 1.
